// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the
// per-opcode control decode used by the decode stage.
package riscv_pkg;

   localparam int XLEN      = 32;
   localparam int ADDR_SIZE = 5;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

   typedef struct packed {
      logic      use_rs1;
      logic      use_rs2;
      logic      writes_rd;
      logic      illegal;
      imm_type_e imm_type;
   } dec_ctrl_t;

   function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opcode);
      dec_ctrl_t c;
      c.use_rs1   = 1'b1;
      c.use_rs2   = 1'b0;
      c.writes_rd = 1'b0;
      c.illegal   = 1'b0;
      c.imm_type  = IMM_NONE;
      case (opcode)
         OP: begin
            c.use_rs2   = 1'b1;
            c.writes_rd = 1'b1;
         end
         OP_IMM, LOAD, JALR, SYSTEM: begin
            c.writes_rd = 1'b1;
            c.imm_type  = IMM_I;
         end
         STORE: begin
            c.use_rs2  = 1'b1;
            c.imm_type = IMM_S;
         end
         BRANCH: begin
            c.use_rs2  = 1'b1;
            c.imm_type = IMM_B;
         end
         JAL: begin
            c.use_rs1   = 1'b0;
            c.writes_rd = 1'b1;
            c.imm_type  = IMM_J;
         end
         LUI, AUIPC: begin
            c.use_rs1   = 1'b0;
            c.writes_rd = 1'b1;
            c.imm_type  = IMM_U;
         end
         default: begin
            c.illegal = 1'b1;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, regfile, writeback and execute signals of the decode stage.
// The slave modport is the decode stage's view; master is the environment's.
interface decode_stage_if #(
   parameter int XLEN      = riscv_pkg::XLEN,
   parameter int ADDR_SIZE = riscv_pkg::ADDR_SIZE
);
   logic                 if_valid;
   logic                 if_ready;
   logic [31:0]          if_instr;
   logic [XLEN-1:0]      if_pc;
   logic                 flush;
   logic                 rf_read_enable1;
   logic                 rf_read_enable2;
   logic [ADDR_SIZE-1:0] rf_read_addr1;
   logic [ADDR_SIZE-1:0] rf_read_addr2;
   logic [XLEN-1:0]      rf_read_data1;
   logic [XLEN-1:0]      rf_read_data2;
   logic                 wb_valid;
   logic [ADDR_SIZE-1:0] wb_addr;
   logic                 id_valid;
   logic                 id_ready;
   logic [XLEN-1:0]      id_pc;
   logic [XLEN-1:0]      id_rs1_data;
   logic [XLEN-1:0]      id_rs2_data;
   logic [XLEN-1:0]      id_imm;
   logic [ADDR_SIZE-1:0] id_rd;
   logic [6:0]           id_opcode;
   logic [2:0]           id_funct3;
   logic [6:0]           id_funct7;
   logic                 id_reg_write;
   logic                 id_illegal;

   modport slave (
      input  if_valid, if_instr, if_pc, flush, rf_read_data1, rf_read_data2,
             wb_valid, wb_addr, id_ready,
      output if_ready, rf_read_enable1, rf_read_enable2, rf_read_addr1, rf_read_addr2,
             id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rd, id_opcode,
             id_funct3, id_funct7, id_reg_write, id_illegal
   );

   modport master (
      output if_valid, if_instr, if_pc, flush, rf_read_data1, rf_read_data2,
             wb_valid, wb_addr, id_ready,
      input  if_ready, rf_read_enable1, rf_read_enable2, rf_read_addr1, rf_read_addr2,
             id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rd, id_opcode,
             id_funct3, id_funct7, id_reg_write, id_illegal
   );
endinterface

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediate and sign-extends it to XLEN.
module imm_gen #(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic [31:0]          i_instr,
   input  riscv_pkg::imm_type_e i_imm_type,
   output logic [XLEN-1:0]      o_imm
);
   import riscv_pkg::*;

   logic [31:0] w_imm32;
   logic        w_unused_opcode;

   assign w_unused_opcode = ^i_instr[6:0];

   // Format-specific bit gather; B and J carry an implicit zero LSB.
   always_comb begin
      w_imm32 = 32'h0000_0000;
      case (i_imm_type)
         IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   w_imm32 = {i_instr[31:12], 12'h000};
         IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
         default: w_imm32 = 32'h0000_0000;
      endcase
   end

   assign o_imm = XLEN'($signed(w_imm32));
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: fetch handshake, regfile read, ID/EX register toward execute.
// Define DECODE_SCOREBOARD_EN to stall on read-after-write hazards against in-flight writes.
module decode_stage #(
   parameter int XLEN      = riscv_pkg::XLEN,
   parameter int ADDR_SIZE = riscv_pkg::ADDR_SIZE
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);
   import riscv_pkg::*;

   dec_ctrl_t            w_ctrl;
   logic [ADDR_SIZE-1:0] w_rs1;
   logic [ADDR_SIZE-1:0] w_rs2;
   logic [ADDR_SIZE-1:0] w_rd;
   logic [XLEN-1:0]      w_imm;
   logic [XLEN-1:0]      w_rs1_data;
   logic [XLEN-1:0]      w_rs2_data;
   logic                 w_reg_write;
   logic                 w_stall;
   logic                 w_if_ready;
   logic                 w_accept;

   logic                 r_id_valid;
   logic [XLEN-1:0]      r_id_pc;
   logic [XLEN-1:0]      r_id_rs1_data;
   logic [XLEN-1:0]      r_id_rs2_data;
   logic [XLEN-1:0]      r_id_imm;
   logic [ADDR_SIZE-1:0] r_id_rd;
   logic [6:0]           r_id_opcode;
   logic [2:0]           r_id_funct3;
   logic [6:0]           r_id_funct7;
   logic                 r_id_reg_write;
   logic                 r_id_illegal;

   assign w_ctrl      = decode_ctrl(bus.if_instr[6:0]);
   assign w_rs1       = bus.if_instr[19:15];
   assign w_rs2       = bus.if_instr[24:20];
   assign w_rd        = bus.if_instr[11:7];
   assign w_reg_write = w_ctrl.writes_rd && (w_rd != {ADDR_SIZE{1'b0}});
   assign w_rs1_data  = (w_rs1 == {ADDR_SIZE{1'b0}}) ? {XLEN{1'b0}} : bus.rf_read_data1;
   assign w_rs2_data  = (w_rs2 == {ADDR_SIZE{1'b0}}) ? {XLEN{1'b0}} : bus.rf_read_data2;

   assign bus.rf_read_addr1   = w_rs1;
   assign bus.rf_read_addr2   = w_rs2;
   assign bus.rf_read_enable1 = bus.if_valid && w_ctrl.use_rs1;
   assign bus.rf_read_enable2 = bus.if_valid && w_ctrl.use_rs2;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .i_instr    (bus.if_instr),
      .i_imm_type (w_ctrl.imm_type),
      .o_imm      (w_imm)
   );

`ifdef DECODE_SCOREBOARD_EN
   localparam int NREGS = 2 ** ADDR_SIZE;
   localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_set_mask;
   logic [NREGS-1:0] w_clr_mask;
   logic [NREGS-1:0] w_busy_next;

   assign w_stall = (w_ctrl.use_rs1 && r_busy[w_rs1]) || (w_ctrl.use_rs2 && r_busy[w_rs2]);

   // Clear is applied before set so a same-index set wins; x0 never goes busy.
   assign w_set_mask  = (w_accept && w_reg_write) ? (ONE_HOT0 << w_rd) : {NREGS{1'b0}};
   assign w_clr_mask  = (bus.wb_valid ? (ONE_HOT0 << bus.wb_addr) : {NREGS{1'b0}})
                      | ((bus.flush && r_id_valid && r_id_reg_write) ? (ONE_HOT0 << r_id_rd)
                                                                     : {NREGS{1'b0}});
   assign w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~ONE_HOT0;

   // Busy vector: one bit per register with a write still in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy <= {NREGS{1'b0}};
      end else begin
         r_busy <= w_busy_next;
      end
   end
`else
   logic w_unused_wb;

   assign w_stall     = 1'b0;
   assign w_unused_wb = ^{bus.wb_valid, bus.wb_addr};
`endif

   assign w_if_ready = (!r_id_valid || bus.id_ready) && !w_stall && !bus.flush;
   assign w_accept   = bus.if_valid && w_if_ready;
   assign bus.if_ready = w_if_ready;

   // ID/EX register: flush kills, accept loads, an execute handshake alone drains.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_id_valid     <= 1'b0;
         r_id_pc        <= {XLEN{1'b0}};
         r_id_rs1_data  <= {XLEN{1'b0}};
         r_id_rs2_data  <= {XLEN{1'b0}};
         r_id_imm       <= {XLEN{1'b0}};
         r_id_rd        <= {ADDR_SIZE{1'b0}};
         r_id_opcode    <= 7'b0000000;
         r_id_funct3    <= 3'b000;
         r_id_funct7    <= 7'b0000000;
         r_id_reg_write <= 1'b0;
         r_id_illegal   <= 1'b0;
      end else if (bus.flush) begin
         r_id_valid <= 1'b0;
      end else if (w_accept) begin
         r_id_valid     <= 1'b1;
         r_id_pc        <= bus.if_pc;
         r_id_rs1_data  <= w_rs1_data;
         r_id_rs2_data  <= w_rs2_data;
         r_id_imm       <= w_imm;
         r_id_rd        <= w_rd;
         r_id_opcode    <= bus.if_instr[6:0];
         r_id_funct3    <= bus.if_instr[14:12];
         r_id_funct7    <= bus.if_instr[31:25];
         r_id_reg_write <= w_reg_write;
         r_id_illegal   <= w_ctrl.illegal;
      end else if (r_id_valid && bus.id_ready) begin
         r_id_valid <= 1'b0;
      end
   end

   assign bus.id_valid     = r_id_valid;
   assign bus.id_pc        = r_id_pc;
   assign bus.id_rs1_data  = r_id_rs1_data;
   assign bus.id_rs2_data  = r_id_rs2_data;
   assign bus.id_imm       = r_id_imm;
   assign bus.id_rd        = r_id_rd;
   assign bus.id_opcode    = r_id_opcode;
   assign bus.id_funct3    = r_id_funct3;
   assign bus.id_funct7    = r_id_funct7;
   assign bus.id_reg_write = r_id_reg_write;
   assign bus.id_illegal   = r_id_illegal;
endmodule
